// File: rtl/spell_mem_arbiter_if.sv
// Bus bundle for spell_mem_arbiter: both requester ports plus the memory side.
// slave  = arbiter view; master = requesters/memory view (testbench or parent).
interface spell_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              p0_req,   p1_req;
  logic              p0_write, p1_write;
  logic [1:0]        p0_type,  p1_type;
  logic [ADDR_W-1:0] p0_addr,  p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              p0_done,  p1_done;
  logic              p0_err,   p1_err;
  logic              mem_select;
  logic              mem_write;
  logic [1:0]        mem_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              grant;

  modport slave (
    input  p0_req, p1_req, p0_write, p1_write, p0_type, p1_type,
           p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata, mem_ready,
    output p0_rdata, p1_rdata, p0_done, p1_done, p0_err, p1_err,
           mem_select, mem_write, mem_type, mem_addr, mem_wdata, busy, grant
  );

  modport master (
    output p0_req, p1_req, p0_write, p1_write, p0_type, p1_type,
           p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata, mem_ready,
    input  p0_rdata, p1_rdata, p0_done, p1_done, p0_err, p1_err,
           mem_select, mem_write, mem_type, mem_addr, mem_wdata, busy, grant
  );
endinterface

// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter: round-robin share of one SPELL memory between the core
// (port 0) and the host/debug loader (port 1). One access in flight at a time;
// request fields are latched at grant and held on mem_* until mem_ready.
// Optional: define SPELL_MEM_ARB_TIMEOUT_EN to abort an access that sees no
// mem_ready within TIMEOUT_CYCLES cycles (done+err to the owner).
module spell_mem_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  spell_mem_arbiter_if.slave   bus
);
  // Memory type encodings of the SPELL memory (data store / code store).
  localparam logic [1:0] TYPE_DATA = 2'b00;
  localparam logic [1:0] TYPE_CODE = 2'b01;

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  // Per-port request fields packed by port index.
  logic [1:0]                   req, wr;
  logic [1:0][1:0]              typ;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][DATA_W-1:0]       wdata;
  assign req   = {bus.p1_req,   bus.p0_req};
  assign wr    = {bus.p1_write, bus.p0_write};
  assign typ   = {bus.p1_type,  bus.p0_type};
  assign addr  = {bus.p1_addr,  bus.p0_addr};
  assign wdata = {bus.p1_wdata, bus.p0_wdata};

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   grant_q, grant_d;
  logic                   sel_q, sel_d;
  logic                   mwr_q, mwr_d;
  logic [1:0]             mtype_q, mtype_d;
  logic [ADDR_W-1:0]      maddr_q, maddr_d;
  logic [DATA_W-1:0]      mwdata_q, mwdata_d;
  logic [1:0]             done_q, done_d;
  logic [1:0]             err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                   win;
  logic                   type_ok;

`ifdef SPELL_MEM_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Winner: lone requester, or on a tie the port not served last.
  always_comb begin
    win     = (req == 2'b11) ? ~last_q : req[1];
    type_ok = (typ[win] == TYPE_DATA) || (typ[win] == TYPE_CODE);
  end

  // Next-state and output register computation.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    mwr_d    = mwr_q;
    mtype_d  = mtype_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        sel_d = 1'b0;
        if (|req) begin
          grant_d  = win;
          last_d   = win;
          mwr_d    = wr[win];
          mtype_d  = typ[win];
          maddr_d  = addr[win];
          mwdata_d = wdata[win];
          if (type_ok) begin
            state_d  = S_ACCESS;
            sel_d    = 1'b1;
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            // Bad type never touches memory: reject on the next cycle.
            done_d[win] = 1'b1;
            err_d[win]  = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          sel_d           = 1'b0;
          done_d[grant_q] = 1'b1;
          if (!mwr_q) rdata_d[grant_q] = bus.mem_rdata;
          state_d         = S_IDLE;
        end
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          sel_d           = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          state_d         = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset drops select so memory re-arms.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      sel_q    <= 1'b0;
      mwr_q    <= 1'b0;
      mtype_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      mwr_q    <= mwr_d;
      mtype_q  <= mtype_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign bus.mem_select = sel_q;
  assign bus.mem_write  = mwr_q;
  assign bus.mem_type   = mtype_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.p0_done    = done_q[0];
  assign bus.p1_done    = done_q[1];
  assign bus.p0_err     = err_q[0];
  assign bus.p1_err     = err_q[1];
  assign bus.p0_rdata   = rdata_q[0];
  assign bus.p1_rdata   = rdata_q[1];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.grant      = grant_q;
endmodule
